// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage core (load-use, branch squash, memory wait, halt).
// Define HAZARD_STALL_CNT_EN to add the stall_cycles / bubble_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_rs_use,
  input  logic             if_id_rt_use,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_rw,
  input  logic             id_ex_memrd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             mem_wb_hlt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             halted,
  output logic             mem_err
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      bubble_cnt
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [1:0]        state_q, state_d;
  logic              pend_q, pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_q, err_d;
  logic              lu;
  logic              resolve, take_br, freeze, counting;

  // Load-use hazard: register 0 never stalls
  assign lu = id_ex_memrd & id_ex_rw & (id_ex_rd != '0) &
              ((if_id_rs_use & (id_ex_rd == if_id_rs)) |
               (if_id_rt_use & (id_ex_rd == if_id_rt)));

  assign wait_inc = (wait_q == WAIT_SAT) ? wait_q : wait_q + WAIT_W'(1);

  // Next-state and zero-latency pipeline control
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    halted       = 1'b0;
    mem_err      = err_q;
    state_d      = state_q;
    pend_d       = pend_q;
    wait_d       = wait_q;
    err_d        = err_q;
    resolve      = 1'b0;
    take_br      = 1'b0;
    freeze       = 1'b0;
    counting     = 1'b0;

    case (state_q)
      ST_HALTED: begin
        freeze = 1'b1;
        halted = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          freeze   = 1'b1;
          counting = 1'b1;
          pend_d   = pend_q | branch_taken;
          wait_d   = wait_inc;
        end else begin
          resolve = 1'b1;
          take_br = pend_q | branch_taken;
          pend_d  = 1'b0;
          wait_d  = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        if (mem_busy && !mem_wb_hlt) begin
          freeze   = 1'b1;
          counting = 1'b1;
          pend_d   = branch_taken;
          wait_d   = WAIT_W'(1);
          state_d  = ST_MEM_WAIT;
        end else begin
          resolve = 1'b1;
          take_br = branch_taken;
        end
      end
    endcase

    // A squashed IF/ID instruction cannot cause a load-use bubble
    if (resolve) begin
      if (mem_wb_hlt) begin
        freeze  = 1'b1;
        state_d = ST_HALTED;
      end else if (take_br) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (counting && (wait_d >= WAIT_LIM)) err_d = 1'b1;

    if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      halted       = 1'b0;
      mem_err      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // A load-use bubble is the only case with pc_write low and id_ex_write high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_cnt   <= '0;
    end else begin
      if (!pc_write && (state_q != ST_HALTED) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (!pc_write && id_ex_write && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage, 16-register core.
- Complements the EX-stage operand forwarding logic. Forwarding resolves RAW hazards it can bypass; this block handles what it cannot:
  - load-use stalls,
  - taken-branch squashes,
  - data/instruction memory wait stalls,
  - halt.
- Drives pipeline-register write enables and flushes from ID/EX and EX/MEM producer-side fields.

Parameters:
- REG_W, 4, register-address width.
- WAIT_W, 8, width of the memory-wait counter.
- MAX_WAIT, 200, wait cycles after which mem_err sets (must be < 2^WAIT_W).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_id_rs  input  REG_W  source reg A of instruction in IF/ID.
- if_id_rt  input  REG_W  source reg B of instruction in IF/ID.
- if_id_rs_use  input  1  instruction in IF/ID reads rs.
- if_id_rt_use  input  1  instruction in IF/ID reads rt.
- id_ex_rd  input  REG_W  destination of instruction in ID/EX.
- id_ex_rw  input  1  ID/EX instruction writes a register.
- id_ex_memrd  input  1  ID/EX instruction is a load.
- branch_taken  input  1  EX resolved taken branch/jump this cycle.
- mem_busy  input  1  data or instruction memory not ready.
- mem_wb_hlt  input  1  HLT instruction in MEM/WB.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID enable.
- if_id_flush  output  1  load NOP into IF/ID.
- id_ex_write  output  1  ID/EX enable.
- id_ex_flush  output  1  load NOP (bubble) into ID/EX.
- ex_mem_write  output  1  EX/MEM and MEM/WB enable.
- halted  output  1  core halted.
- mem_err  output  1  sticky memory-timeout flag.

Behaviour:
- States (registered): RUN, MEM_WAIT, HALTED. Additional registers: pend_flush (1 bit), wait_cnt (WAIT_W bits), mem_err.
- Outputs are combinational from state and inputs; all hazard decisions take effect in the same cycle (zero latency).
- While rst is high, outputs are forced as follows:
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0;
  - if_id_flush, id_ex_flush = 1;
  - halted, mem_err = 0.
- Reset also sets state=RUN, pend_flush=0, wait_cnt=0.
- Load-use detection (lu):
  - lu = id_ex_memrd & id_ex_rw & (id_ex_rd != 0) & ((if_id_rs_use & id_ex_rd == if_id_rs) | (if_id_rt_use & id_ex_rd == if_id_rt)).
  - Register 0 never causes a stall.
- Priority in RUN, highest first:
  1. mem_wb_hlt: all write enables = 0, flushes = 0; next state HALTED.
  2. mem_busy: all write enables = 0 (full freeze), flushes = 0; pend_flush <= branch_taken; wait_cnt <= 1; next state MEM_WAIT.
  3. branch_taken: all write enables = 1, if_id_flush = 1, id_ex_flush = 1. The squashed IF/ID instruction's lu is ignored.
  4. lu: pc_write = 0, if_id_write = 0, id_ex_flush = 1, id_ex_write = 1, ex_mem_write = 1. Exactly one bubble; the next cycle re-evaluates lu (now 0 because the load has advanced).
  5. Otherwise: all write enables = 1, flushes = 0.
- MEM_WAIT:
  - While mem_busy: full freeze; wait_cnt increments, saturating at 2^WAIT_W-1. When wait_cnt reaches MAX_WAIT, mem_err <= 1 (sticky until rst).
  - pend_flush |= branch_taken.
  - On the cycle mem_busy = 0: if pend_flush | branch_taken, apply branch behaviour (item 3); otherwise apply lu/normal behaviour (items 4/5). Then clear pend_flush and wait_cnt; next state RUN.
  - mem_wb_hlt arriving during MEM_WAIT is ignored until the release cycle, then handled as in RUN with top priority.
- HALTED: all write enables = 0, flushes = 0, halted = 1. Only rst exits this state.
- rst asserted mid-stall or mid-wait: immediate return to reset values; no pending flush survives.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles (32 bits).
  - Adds output bubble_cnt (16 bits).
  - stall_cycles increments each cycle pc_write = 0 while not HALTED and rst low.
  - bubble_cnt increments on each lu bubble.
  - Both counters saturate, and both clear on rst.
- When undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Load-use: id_ex_memrd=1, id_ex_rw=1, id_ex_rd=5, if_id_rs=5, rs_use=1 -> for exactly 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (id_ex_memrd=0) all enables=1.
- Register-0 / unused-operand cases: id_ex_rd=0 matching; or rd=3 matching rt with rt_use=0 -> no stall.
- Branch vs load-use in the same cycle: branch_taken=1 with lu=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
- Branch during memory wait: mem_busy high for 4 cycles with branch_taken pulsed in cycle 2 -> 4 cycles all enables=0; release cycle shows both flushes=1; mem_err stays 0.
- Timeout: mem_busy held 250 cycles with MAX_WAIT=200 -> mem_err rises after the 200th wait cycle and stays 1 after mem_busy drops, until rst.
- Halt and reset: mem_wb_hlt=1 -> halted=1 and enables=0 indefinitely; async rst pulse mid-cycle -> outputs reach reset values without a clock edge; after release, state is RUN with enables=1.
